hazard_stall_controller: RTL and testbench

//  Scoreboard-based hazard controller for the 5-stage pipeline. Sits beside
//  the decode stage, tracks in-flight register writes, and stalls the

---
 rtl/hazard_stall_controller_if.sv | 33 +++
 rtl/hazard_stall_controller.sv | 147 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Decode-side hazard interface: ID instruction fields and redirect in, pipeline
// enables, flush/bubble controls and stall statistics out.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             redirect;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, redirect,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, redirect,
    output pc_write, ifid_write, ifid_flush, idex_bubble, stall, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Scoreboard RAW-hazard stall / redirect flush controller for the decode stage.
// Optional feature macro: FORWARDING_EN (only loads occupy the scoreboard).
module hazard_stall_controller #(
  parameter int WB_LATENCY   = 3,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  hazard_stall_controller_if.slave hz
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;

  state_t           state_q;
  logic [1:0]       flush_cnt_q;
  logic [1:0]       sb_q [32];
  logic [1:0]       sb_d [32];
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  logic       rs_busy;
  logic       rt_busy;
  logic       haz;
  logic       redirect_active;
  logic       issue;
  logic [1:0] issue_lat;

  logic pc_write_o;
  logic ifid_write_o;
  logic ifid_flush_o;
  logic idex_bubble_o;
  logic stall_o;

`ifdef FORWARDING_EN
  localparam int unused_wb_latency = WB_LATENCY;
  assign issue_lat = hz.id_mem_read ? 2'(LOAD_LATENCY) : 2'd0;
`else
  localparam int unused_load_latency = LOAD_LATENCY;
  logic unused_mem_read;
  assign unused_mem_read = hz.id_mem_read;
  assign issue_lat       = 2'(WB_LATENCY);
`endif

  always_comb begin
    rs_busy         = hz.id_uses_rs && (hz.id_rs != 5'd0) && (sb_q[hz.id_rs] != 2'd0);
    rt_busy         = hz.id_uses_rt && (hz.id_rt != 5'd0) && (sb_q[hz.id_rt] != 2'd0);
    haz             = hz.id_valid && (rs_busy || rt_busy);
    redirect_active = hz.redirect || (state_q == ST_FLUSH);
    issue           = hz.id_valid && !haz && !redirect_active;
  end

  // A fresh issue overrides the same-cycle decrement of its destination entry.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      sb_d[i] = (sb_q[i] != 2'd0) ? sb_q[i] - 2'd1 : 2'd0;
    end
    if (issue && hz.id_reg_write && (hz.id_dest != 5'd0)) begin
      sb_d[hz.id_dest] = issue_lat;
    end
    sb_d[0] = 2'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) sb_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 32; i++) sb_q[i] <= sb_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.redirect) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= 2'(FLUSH_CYCLES);
          end else if (haz) begin
            state_q <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (hz.redirect) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= 2'(FLUSH_CYCLES);
          end else if (!haz) begin
            state_q <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (hz.redirect) begin
            flush_cnt_q <= 2'(FLUSH_CYCLES);
          end else if (flush_cnt_q == 2'd1) begin
            state_q <= ST_RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - 2'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Reset forces the pipeline frozen with IF/ID cleared and ID/EX bubbled.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    stall_o       = 1'b0;
    if (!rst_ni) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (redirect_active) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (haz) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      stall_o       = 1'b1;
    end
  end

  assign stall_count_d = (stall_o && (stall_count_q != '1)) ? stall_count_q + 1'b1
                                                            : stall_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_count_q <= '0;
    else         stall_count_q <= stall_count_d;
  end

  assign hz.pc_write    = pc_write_o;
  assign hz.ifid_write  = ifid_write_o;
  assign hz.ifid_flush  = ifid_flush_o;
  assign hz.idex_bubble = idex_bubble_o;
  assign hz.stall       = stall_o;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: load-use stalls, $0 writes,
// bubbles, redirect flushes, async reset mid-stall and counter saturation.
module tb_hazard_stall_controller;
  localparam int CNT_W        = 10;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int SAT_TARGET   = (1 << CNT_W) + 5;
`ifdef FORWARDING_EN
  localparam int STALLS = 1;
`else
  localparam int STALLS = 3;
`endif

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, StallOut}
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_RESET = 5'b00110;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_cnt;
  int   total;
  int   k;
  logic exp_stall;

  hazard_stall_controller_if #(.CNT_W(CNT_W)) hz_if ();

  hazard_stall_controller #(
    .WB_LATENCY  (3),
    .LOAD_LATENCY(1),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {hz_if.pc_write, hz_if.ifid_write, hz_if.ifid_flush, hz_if.idex_bubble, hz_if.stall};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] exp_outs);
    #1;
    check({tag, "_outs"}, 32'(outs()), 32'(exp_outs));
    check({tag, "_count"}, 32'(hz_if.stall_count), 32'(exp_cnt));
    $display("step %-14s outs=%b count=%0d", tag, outs(), hz_if.stall_count);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dest,
                        input logic rw, input logic mr, input logic red);
    hz_if.id_valid     = v;
    hz_if.id_rs        = rs;
    hz_if.id_rt        = rt;
    hz_if.id_uses_rs   = urs;
    hz_if.id_uses_rt   = urt;
    hz_if.id_dest      = dest;
    hz_if.id_reg_write = rw;
    hz_if.id_mem_read  = mr;
    hz_if.redirect     = red;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset", O_RESET);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step("released", O_RUN);
    tick();

    // lw $8,0($1) then add $9,$8,$8
    set_id(1, 5'd1, 5'd8, 1, 0, 5'd8, 1, 1, 0);
    step("lw8", O_RUN);
    tick();
    set_id(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
    for (int i = 0; i < STALLS; i++) begin
      step("add9_stall", O_STALL);
      tick();
      exp_cnt++;
    end
    step("add9_issue", O_RUN);
    tick();
    drain();

    // addi $0,$0,5 then add $2,$0,$0: writes to $0 never create a hazard
    set_id(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0);
    step("addi0", O_RUN);
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd2, 1, 0, 0);
    step("add2_r0", O_RUN);
    tick();
    drain();

    // bubble reading a busy register with RegWrite set: no stall, no sb write
    set_id(1, 5'd1, 5'd8, 1, 0, 5'd8, 1, 1, 0);
    step("lw8_b", O_RUN);
    tick();
    set_id(0, 5'd8, 5'd8, 1, 1, 5'd13, 1, 1, 0);
    step("bubble", O_RUN);
    tick();
    set_id(1, 5'd13, 5'd0, 1, 0, 5'd14, 1, 0, 0);
    step("use13", O_RUN);
    tick();
    drain();

    // load-use with redirect in the first stall cycle
    set_id(1, 5'd1, 5'd10, 1, 0, 5'd10, 1, 1, 0);
    step("lw10", O_RUN);
    tick();
    set_id(1, 5'd10, 5'd10, 1, 1, 5'd11, 1, 0, 1);
    step("redir_stall", O_FLUSH);
    tick();
    hz_if.redirect = 1'b0;
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      step("flush", O_FLUSH);
      tick();
    end
    set_id(1, 5'd11, 5'd0, 1, 0, 5'd12, 1, 0, 0);
    step("use11", O_RUN);
    tick();
    drain();

    // redirect arriving during FLUSH reloads the flush counter
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("redir_run", O_FLUSH);
    tick();
    step("redir_flush", O_FLUSH);
    tick();
    hz_if.redirect = 1'b0;
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      step("reload_flush", O_FLUSH);
      tick();
    end
    step("after_flush", O_RUN);
    tick();

    // async reset in the middle of a stall
    set_id(1, 5'd1, 5'd8, 1, 0, 5'd8, 1, 1, 0);
    step("lw8_r", O_RUN);
    tick();
    set_id(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
    step("stall_pre_rst", O_STALL);
    tick();
    exp_cnt++;
    rst_n   = 1'b0;
    exp_cnt = 0;
    step("rst_mid_stall", O_RESET);
    tick();
    rst_n = 1'b1;
    step("post_rst_add", O_RUN);
    tick();
    drain();

    // lw $8,0($8) held in ID: repeated self-dependent stalls saturate the counter
    set_id(1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0);
    total = 0;
    k     = 0;
    while (total < SAT_TARGET) begin
      #1;
      exp_stall = ((k % (STALLS + 1)) != 0);
      check("sat_stall", 32'(hz_if.stall), 32'(exp_stall));
      check("sat_count", 32'(hz_if.stall_count), 32'((total < CNT_MAX) ? total : CNT_MAX));
      tick();
      if (exp_stall) total++;
      k++;
    end
    #1;
    check("sat_final", 32'(hz_if.stall_count), 32'(CNT_MAX));
    $display("step saturation   cycles=%0d stalls=%0d count=%0h", k, total, hz_if.stall_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
